// File: rtl/io_console_tx_pkg.sv
// Shared types and constants for the IO console transmitter.
// Bus access kinds, IO port map and STATUS word layout.
package io_console_tx_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_R = 2'd0,
        MEM_ACCESS_W = 2'd1,
        MEM_ACCESS_X = 2'd2
    } mem_access_t;

    localparam logic [31:0] IO_ADDR_HLT    = 32'd0;
    localparam logic [31:0] IO_ADDR_CHAR   = 32'd1;
    localparam logic [31:0] IO_ADDR_STATUS = 32'd2;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_BUSY      = 2;
    localparam int STATUS_COUNT_LSB = 8;

endpackage

// File: rtl/io_tx_fifo.sv
// Character FIFO between the bus decode and the UART shifter.
// Power-of-two depth, pointers wrap naturally.
module io_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_console_tx.sv
// Port-mapped console: bus decode, char FIFO and 8N1 UART transmitter.
// Drives a registered TX line and a sticky halt / drained handshake.
module io_console_tx
    import io_console_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic        db_io,
    input  logic [31:0] db_addr,
    input  logic [31:0] db_dataOut,
    input  mem_access_t db_accessType,
    output logic        db_ready,
    output logic [31:0] db_dataIn,
    output logic        tx,
    output logic        hlt,
    output logic        drained
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_q;

    logic          wr;
    logic          rd;
    logic          wr_char;
    logic          push;
    logic          pop;
    logic          busy;
    logic          baud_last;
    logic [7:0]    fifo_dout;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic          unused_data;

    assign wr        = db_io & (db_accessType == MEM_ACCESS_W);
    assign rd        = db_io & (db_accessType == MEM_ACCESS_R);
    assign wr_char   = wr & (db_addr == IO_ADDR_CHAR);
    assign db_ready  = ~(wr_char & full);
    assign push      = wr_char & ~full;
    assign pop       = (state == S_IDLE) & ~empty;
    assign busy      = (state != S_IDLE);
    assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
    assign tx        = tx_q;

    assign unused_data = ^db_dataOut[31:8];

    always_comb begin
        status = '0;
        status[STATUS_EMPTY] = empty;
        status[STATUS_FULL]  = full;
        status[STATUS_BUSY]  = busy;
        status[STATUS_COUNT_LSB +: 8] = 8'(count);
    end

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .din   (db_dataOut[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            hlt       <= 1'b0;
            drained   <= 1'b0;
            db_dataIn <= '0;
        end else begin
            if (wr && db_addr == IO_ADDR_HLT) begin
                hlt <= 1'b1;
            end
            if (rd) begin
                db_dataIn <= (db_addr == IO_ADDR_STATUS) ? status : '0;
            end
            drained <= hlt & empty & ~busy;
        end
    end

    // tx is updated on the same edge as the state change so it never lags a bit
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shift <= fifo_dout;
                        baud  <= '0;
                        state <= S_START;
                        tx_q  <= 1'b0;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx_q    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= S_IDLE;
                        tx_q  <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
